fc_argmax_sequencer: RTL
========================

# fc_argmax_sequencer

Sequential classification stage at the tail of the FC module. Accepts the final FC layer's LAYER_SIZE outputs as a valid/ready stream, one word per accepted beat. Tracks the running maximum with a single shared comparator and presents the winning class index, with its value, on an output handshake. This replaces the fully parallel comparator chain with a time-multiplexed one, sized for designs where the FC layer emits results serially.

## Interface
Parameters:
- WORD_SIZE, 16, width of each FC output word, signed two's complement
- LAYER_SIZE, 10, number of classes per classification; legal range ≥ 2
- N (localparam), $clog2(LAYER_SIZE), index width

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse that begins a classification; sampled only in IDLE
- in_valid  in  1  in_data holds a valid FC output word
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  WORD_SIZE  FC output word for class index = beat count
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_idx  out  N  index of the maximum word
- out_val  out  WORD_SIZE  value of the maximum word
- busy  out  1  high in COLLECT and DONE

## Operation
- FSM states are IDLE, COLLECT and DONE.
  - IDLE → COLLECT when start=1.
  - COLLECT → DONE on acceptance of beat LAYER_SIZE-1.
  - DONE → IDLE when out_valid && out_ready.
- A beat is accepted when in_valid && in_ready. in_ready = (state==COLLECT).
- Beat counter cnt (N bits) is cleared on entry to COLLECT and increments per accepted beat. It never wraps within a classification because the FSM leaves COLLECT at LAYER_SIZE-1.
- Beat 0: max_val ← in_data and max_idx ← 0, unconditionally.
- Beat k > 0: if in_data > max_val (signed, strict), then max_val ← in_data and max_idx ← k. Otherwise both hold.
- Ties keep the lowest index.
- In DONE, out_idx = max_idx and out_val = max_val. Both are held stable while out_valid=1 and out_ready=0.
- start is ignored outside IDLE. in_valid is ignored outside COLLECT; no beat is consumed there.
- Gaps (in_valid=0) during COLLECT stall the counter and the comparator state indefinitely.
- There is no abort input. rst is the only way to cancel a classification.

## Timing
- Reset values:
  - state = IDLE, cnt = 0, max_val = 0, max_idx = 0
  - in_ready = 0, out_valid = 0, busy = 0
  - out_idx = 0, out_val = 0
- rst has priority over every other input in the same cycle. Reset mid-COLLECT or mid-DONE discards the partial or pending result. No out_valid follows.
- start sampled at edge t: in_ready=1 from cycle t+1.
- Last beat accepted at edge t: out_valid=1 and result stable from cycle t+1, with in_ready=0 in that same cycle.
- Minimum latency from first accepted beat to out_valid is LAYER_SIZE cycles, with no gaps.
- Result accepted at edge t: state IDLE at t+1. A start high in cycle t+1 is taken, giving back-to-back throughput of LAYER_SIZE+2 cycles per classification.
- A start asserted in the same cycle as the out_valid && out_ready handshake is ignored, because the FSM is still in DONE.
- Outputs are registered. There is no combinational path from in_data or out_ready to any output.

## Test plan
- Ascending input: LAYER_SIZE=10, in_data = 0..9, no gaps → out_idx=9, out_val=9, out_valid first high 10 cycles after the first accepted beat.
- Negatives and sign: in_data = {-5,-3,-8,-1,-7,-2,-9,-4,-6,-10} → out_idx=3, out_val=-1 (0xFFFF at WORD_SIZE=16).
- Ties and gaps: in_data = {2,7,7,1,7,0,0,0,0,0} with in_valid deasserted for 3 cycles after beats 1 and 4 → out_idx=1, out_val=7. The counter does not advance during gaps.
- Output backpressure: hold out_ready=0 for 5 cycles in DONE, pulse start and in_valid during that time → out_idx and out_val stable, in_ready=0, no state change. Result accepted on the out_ready cycle, IDLE on the next cycle.
- Reset mid-operation: assert rst after beat 4 of 10 → all outputs return to their reset values next cycle. A new classification {0,0,0,0,0,0,0,0,0,5} then yields out_idx=9, out_val=5, with no residue from the aborted run.
- Back-to-back: two classifications with start issued the cycle after each result handshake → correct indices for both (e.g. 4 then 0), spaced exactly LAYER_SIZE+2 cycles apart.

Source files
------------

// File: rtl/fc_argmax_sequencer_if.sv
// fc_argmax_sequencer_if: input stream, result handshake and status bundle
interface fc_argmax_sequencer_if #(
  parameter int WORD_SIZE  = 16,
  parameter int LAYER_SIZE = 10
);
  localparam int N = $clog2(LAYER_SIZE);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         out_idx;
  logic [WORD_SIZE-1:0] out_val;
  logic                 busy;
  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_val, busy
  );
  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_val, busy
  );
endinterface

// File: rtl/fc_argmax_sequencer.sv
// fc_argmax_sequencer: serial argmax over one FC layer's outputs with a single shared comparator
module fc_argmax_sequencer #(
  parameter int WORD_SIZE  = 16,
  parameter int LAYER_SIZE = 10
) (
  input logic                  clk,
  input logic                  rst,
  fc_argmax_sequencer_if.slave bus
);
  localparam int N = $clog2(LAYER_SIZE);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t                      state, state_nx;
  logic [N-1:0]                cnt, max_idx;
  logic signed [WORD_SIZE-1:0] max_val;
  logic                        accept, last;
  assign accept = bus.in_valid && state == COLLECT;
  assign last   = cnt == N'(LAYER_SIZE - 1);
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state: start only counts in IDLE, result leaves DONE on handshake
  always_comb
    state_nx = state == IDLE    ? (bus.start ? COLLECT : IDLE) :
               state == COLLECT ? (accept && last ? DONE : COLLECT) :
                                  (bus.out_ready ? IDLE : DONE);
  // beat counter and running maximum; beat 0 seeds, later beats win only when strictly greater
  always_ff @(posedge clk)
    if (rst) begin
      cnt     <= '0;
      max_idx <= '0;
      max_val <= '0;
    end else if (state == IDLE && bus.start) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      if (cnt == '0 || $signed(bus.in_data) > max_val) begin
        max_val <= bus.in_data;
        max_idx <= cnt;
      end
    end
  // outputs decode from registers only, so nothing combinational reaches them from the inputs
  always_comb begin
    bus.in_ready  = state == COLLECT;
    bus.out_valid = state == DONE;
    bus.busy      = state != IDLE;
    bus.out_idx   = max_idx;
    bus.out_val   = max_val;
  end
endmodule
